// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: shared constants and types for the writeback controller.
//   XLEN     - integer data width
//   NREG     - number of architectural integer registers
//   AW       - register index width
//   REG_ZERO - index of the hardwired-zero register x0
//   wb_entry_t - one buffered writeback {rd, wd}
package wb_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with a valid/ready push side and a pop strobe.
//   clk, rst      - clock, asynchronous active-high reset
//   push_valid_i  - entry offered on push_data_i
//   push_ready_o  - FIFO can accept (forced low while rst is high)
//   push_data_i   - entry to append at the tail
//   pop_i         - remove the head this edge (ignored when empty)
//   head_o        - current head entry (undefined when empty)
//   count_o       - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import wb_ctrl_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  // Ready depends only on registered count so it never combinationally
  // follows the push/pop inputs.
  assign push_ready_o = !rst && (count_q != CW'(DEPTH));
  assign do_push      = push_valid_i && push_ready_o;
  assign do_pop       = pop_i && (count_q != '0);
  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback controller driving the integer regfile write port.
//   clk, rst             - clock, asynchronous active-high reset
//   alu_valid/rd/wd      - single-cycle ALU result, no backpressure, has priority
//   lsu_valid/ready/rd/wd- LSU result offer into the result FIFO
//   mark_valid/mark_rd   - long-latency op issued; sets busy[mark_rd]
//   we/rd/wd             - registered regfile write port
//   busy                 - per-register pending-write scoreboard (bit 0 always 0)
module wb_ctrl #(
  parameter int unsigned XLEN  = wb_ctrl_pkg::XLEN,
  parameter int unsigned NREG  = wb_ctrl_pkg::NREG,
  parameter int unsigned AW    = wb_ctrl_pkg::AW,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  input  logic            mark_valid,
  input  logic [AW-1:0]   mark_rd,
  output logic            we,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] wd,
  output logic [NREG-1:0] busy
);
  import wb_ctrl_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW+XLEN-1:0] head;
  logic [AW-1:0]      head_rd;
  logic [XLEN-1:0]    head_wd;
  logic [CW-1:0]      fifo_count;
  logic               do_pop;

  logic            we_q, we_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign {head_rd, head_wd} = head;

  // ALU results have strict priority; the FIFO drains only in ALU bubbles.
  assign do_pop = !alu_valid && (fifo_count != '0);

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + XLEN)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (lsu_valid),
    .push_ready_o (lsu_ready),
    .push_data_i  ({lsu_rd, lsu_wd}),
    .pop_i        (do_pop),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    wd_d   = wd_q;
    busy_d = busy_q;

    if (alu_valid) begin
      we_d = (alu_rd != REG_ZERO);
      rd_d = alu_rd;
      wd_d = alu_wd;
    end else if (do_pop) begin
      we_d = (head_rd != REG_ZERO);
      rd_d = head_rd;
      wd_d = head_wd;
    end

    if (do_pop && (head_rd != REG_ZERO)) busy_d[head_rd] = 1'b0;
    // Applied after the clear so a same-edge mark of the popped index wins.
    if (mark_valid && (mark_rd != REG_ZERO)) busy_d[mark_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end

  assign we   = we_q;
  assign rd   = rd_q;
  assign wd   = wd_q;
  assign busy = busy_q;

  // An ALU write to a register with a pending long-latency write is a WAW hazard.
  a_no_waw: assert property (@(posedge clk) disable iff (rst)
    !(alu_valid && busy_q[alu_rd]));

endmodule

// File: tb/tb_wb_ctrl.sv
module tb_wb_ctrl;
  import wb_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alu_valid = 1'b0;
  logic [AW-1:0]   alu_rd = '0;
  logic [XLEN-1:0] alu_wd = '0;
  logic            lsu_valid = 1'b0;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd = '0;
  logic [XLEN-1:0] lsu_wd = '0;
  logic            mark_valid = 1'b0;
  logic [AW-1:0]   mark_rd = '0;
  logic            we;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] wd;
  logic [NREG-1:0] busy;

  int checks = 0;
  int errors = 0;

  wb_ctrl #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_wd     (alu_wd),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_wd     (lsu_wd),
    .mark_valid (mark_valid),
    .mark_rd    (mark_rd),
    .we         (we),
    .rd         (rd),
    .wd         (wd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending LSU results, a busy bit per register,
  // and the last committed write.
  wb_entry_t       mq[$];
  logic [NREG-1:0] m_busy = '0;
  logic            m_we = 1'b0;
  logic [AW-1:0]   m_rd = '0;
  logic [XLEN-1:0] m_wd = '0;

  always @(posedge clk or posedge rst) begin
    wb_entry_t h;
    bit        accept;
    if (rst) begin
      mq.delete();
      m_busy = '0;
      m_we   = 1'b0;
      m_rd   = '0;
      m_wd   = '0;
    end else begin
      accept = lsu_valid && (mq.size() < DEPTH);
      if (alu_valid) begin
        m_we = (alu_rd != 0);
        m_rd = alu_rd;
        m_wd = alu_wd;
      end else if (mq.size() > 0) begin
        h    = mq.pop_front();
        m_we = (h.rd != 0);
        m_rd = h.rd;
        m_wd = h.wd;
        if (h.rd != 0) m_busy[h.rd] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (mark_valid && mark_rd != 0) m_busy[mark_rd] = 1'b1;
      if (accept) mq.push_back('{rd: lsu_rd, wd: lsu_wd});
    end
  end

  always @(negedge clk) begin
    chk("we", we, m_we);
    chk("rd", rd, m_rd);
    chk("wd", wd, m_wd);
    chk("busy", busy, m_busy);
    chk("lsu_ready", lsu_ready, !rst && (mq.size() != DEPTH));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and idle
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("idle_we", we, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", lsu_ready, 1);

    // ALU write, then ALU write to x0
    alu_valid = 1'b1; alu_rd = 5; alu_wd = 32'hDEADBEEF;
    tick();
    chk("alu5_we", we, 1);
    chk("alu5_rd", rd, 5);
    chk("alu5_wd", wd, 32'hDEADBEEF);
    chk("model_alu5_wd", m_wd, 32'hDEADBEEF);
    alu_valid = 1'b0;
    tick();
    chk("alu5_we_drop", we, 0);
    chk("alu5_rd_hold", rd, 5);
    alu_valid = 1'b1; alu_rd = 0; alu_wd = 32'h1234;
    tick();
    chk("x0_we", we, 0);
    alu_valid = 1'b0;

    // Mark x7, then LSU result for x7
    mark_valid = 1'b1; mark_rd = 7;
    tick();
    mark_valid = 1'b0;
    chk("mark7_busy", busy[7], 1);
    chk("model_mark7", m_busy[7], 1);
    lsu_valid = 1'b1; lsu_rd = 7; lsu_wd = 32'h11;
    tick();
    lsu_valid = 1'b0;
    chk("lsu7_not_early", we, 0);
    tick();
    chk("lsu7_we", we, 1);
    chk("lsu7_rd", rd, 7);
    chk("lsu7_wd", wd, 32'h11);
    chk("lsu7_busy_clr", busy[7], 0);

    // Fill under ALU pressure, hold a fifth offer, then drain in order
    alu_valid = 1'b1; alu_rd = 1; alu_wd = $urandom;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1'b1; lsu_rd = AW'(10 + i); lsu_wd = 32'h100 + i;
      tick();
    end
    chk("full_ready", lsu_ready, 0);
    lsu_rd = 14; lsu_wd = 32'h104;
    repeat (2) tick();
    chk("full_ready_held", lsu_ready, 0);
    alu_valid = 1'b0;
    tick();
    chk("drain0_rd", rd, 10);
    chk("drain0_wd", wd, 32'h100);
    chk("drain0_ready", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    chk("drain1_rd", rd, 11);
    for (int k = 2; k < 5; k++) begin
      tick();
      chk("drain_we", we, 1);
      chk("drain_rd", rd, 10 + k);
      chk("drain_wd", wd, 32'h100 + k);
    end
    tick();
    chk("drain_empty_we", we, 0);

    // Same-edge pop of x9 and mark of x9
    lsu_valid = 1'b1; lsu_rd = 9; lsu_wd = 32'h99;
    tick();
    lsu_valid = 1'b0;
    mark_valid = 1'b1; mark_rd = 9;
    tick();
    mark_valid = 1'b0;
    chk("same_edge_rd", rd, 9);
    chk("same_edge_busy9", busy[9], 1);
    chk("model_same_edge", m_busy[9], 1);

    // Count held at 2 with push+pop every edge, pointers wrapping
    alu_valid = 1'b1; alu_rd = 2; alu_wd = 32'h5;
    for (int k = 0; k < 2; k++) begin
      lsu_valid = 1'b1; lsu_rd = AW'(16 + k); lsu_wd = 32'h200 + k;
      tick();
    end
    alu_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      lsu_valid = 1'b1; lsu_rd = AW'(16 + ((j + 2) % 8)); lsu_wd = 32'h200 + j + 2;
      tick();
      chk("wrap_rd", rd, 16 + j);
      chk("wrap_wd", wd, 32'h200 + j);
      chk("wrap_ready", lsu_ready, 1);
    end
    lsu_valid = 1'b0;
    tick();
    chk("wrap_tail8", wd, 32'h208);
    tick();
    chk("wrap_tail9", wd, 32'h209);
    tick();
    chk("wrap_empty_we", we, 0);

    // Reset mid-burst with 3 entries queued
    alu_valid = 1'b1; alu_rd = 3; alu_wd = 32'hABCD;
    mark_valid = 1'b1; mark_rd = 4;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1'b1; lsu_rd = AW'(24 + i); lsu_wd = 32'h300 + i;
      tick();
      mark_valid = 1'b0;
    end
    chk("pre_rst_busy4", busy[4], 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", lsu_ready, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we", we, 0);
    end
    chk("post_rst_ready", lsu_ready, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = AW'($urandom);
      if (m_busy[alu_rd]) alu_rd = '0;
      alu_wd    = $urandom;
      if (!(lsu_valid && mq.size() == DEPTH)) begin
        lsu_valid = ($urandom_range(0, 1) == 0);
        lsu_rd    = AW'($urandom);
        lsu_wd    = $urandom;
      end
      mark_valid = ($urandom_range(0, 7) == 0);
      mark_rd    = AW'($urandom);
      tick();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0; mark_valid = 1'b0;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Writeback controller: the writer end of the integer register file's single write port.
- Merges single-cycle ALU results with buffered multi-cycle load/store (LSU) results, and drives the regfile we/rd/wd port from registered outputs.
- Keeps a per-register busy scoreboard that issue/decode reads to stall on pending long-latency writes.

Parameters:
- XLEN, 32, data width of write data.
- NREG, 32, number of architectural registers.
- AW, 5, register index width (log2 NREG).
- DEPTH, 4, LSU result FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result present this cycle; no backpressure.
- alu_rd  in  AW  ALU destination register.
- alu_wd  in  XLEN  ALU result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  FIFO can accept an LSU result.
- lsu_rd  in  AW  LSU destination register.
- lsu_wd  in  XLEN  LSU result.
- mark_valid  in  1  a long-latency op to mark_rd issued this cycle.
- mark_rd  in  AW  destination of the issued long-latency op.
- we  out  1  regfile write enable.
- rd  out  AW  regfile write index.
- wd  out  XLEN  regfile write data.
- busy  out  NREG  scoreboard; bit i set means a write to xi is pending.

Behaviour:
- Reset, asynchronous:
  - we=0, rd=0, wd=0, busy=0.
  - FIFO emptied, pointers and count = 0.
  - lsu_ready is forced 0 while rst is high.
  - Reset mid-operation discards all queued results and clears all busy bits.
- lsu_ready = !rst && (count != DEPTH); it is a combinational function of registered count only.
- Push: at an edge with lsu_valid && lsu_ready, {lsu_rd, lsu_wd} is written at the tail.
- Commit arbitration, evaluated every edge:
  1. If alu_valid: we<=(alu_rd!=0), rd<=alu_rd, wd<=alu_wd. The FIFO is not popped.
  2. Else if count!=0: pop the head; we<=(head_rd!=0), rd<=head_rd, wd<=head_wd.
  3. Else we<=0. rd and wd hold their previous values.
- Latency:
  - ALU result sampled at edge N appears on we/rd/wd after edge N; the regfile writes it at edge N+1.
  - LSU result pushed at edge N pops no earlier than edge N+1.
- Push and pop at the same edge are both legal: count stays unchanged. This includes a full FIFO only if a pop happens; no push occurs when full because ready=0.
- Pointer wrap-around is modulo DEPTH. Count range is 0..DEPTH.
- ALU-priority starvation of the FIFO is permitted. Upstream guarantees ALU bubbles.
- Scoreboard:
  - set: mark_valid && mark_rd!=0 sets busy[mark_rd] at the edge.
  - clear: a pop with head_rd!=0 clears busy[head_rd] at that edge.
  - Same-edge set and clear of the same index: set wins.
  - busy[0] is constant 0.
  - ALU writes never touch busy.
- x0: never written (we=0) and never marked.
- Protocol violation, flagged by assertion only: alu_valid with busy[alu_rd]=1 (WAW).
- lsu_* inputs must hold stable while lsu_valid && !lsu_ready.

Decomposition:
- Shared package:
  - XLEN, AW, NREG constants.
  - wb_entry_t struct {rd, wd}.
  - REG_ZERO = 0.
- Sub-module sync_fifo (DEPTH, entry width AW+XLEN): valid/ready push, pop strobe, count output, async active-high reset.
- Arbitration, output registers and scoreboard stay in wb_ctrl.

Test Plan:
- Reset, then idle -> we=0, busy=0, lsu_ready=1. Assert rst mid-burst with 3 entries queued -> we=0 immediately, and after release nothing commits.
- alu_valid, rd=5, wd=0xDEADBEEF at edge 1 -> after edge 1 we=1, rd=5, wd=0xDEADBEEF for one cycle. The same with rd=0 -> we stays 0.
- mark rd=7, then an LSU push rd=7 wd=0x11 with no ALU activity:
  - busy[7]=1 after the mark edge.
  - The push is at edge N; at edge N+1 we=1, rd=7, wd=0x11 and busy[7]=0.
- 4 LSU pushes with alu_valid held high -> lsu_ready=0 after the 4th. Fifth offer held; after alu_valid drops, entries commit in order, one per cycle, and ready returns.
- Same edge: pop of a head with rd=9 and mark_rd=9 -> busy[9]=1 after the edge.
- Simultaneous push and pop at count=2 over 8 cycles with wrap -> count stays 2 and data order is preserved.
